// File: rtl/bch_encoder_p8.sv
// Byte-serial systematic BCH encoder: forwards MSG_BEATS message bytes and then
// appends ceil(PAR_W/8) parity bytes. Optional abort port: define BCH_ENC_ABORT_EN.
module bch_encoder_p8 #(
    parameter int               PAR_W     = 13,
    parameter logic [PAR_W-1:0] GEN_POLY  = 13'h001B,
    parameter int               MSG_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef BCH_ENC_ABORT_EN
    input  logic       abort,
`endif
    output logic       out_par,
    output logic       out_last
);

    localparam int PAR_BEATS = (PAR_W + 7) / 8;
    localparam int CNT_W     = (MSG_BEATS > 1) ? $clog2(MSG_BEATS) : 1;
    localparam int PB_W      = (PAR_BEATS > 1) ? $clog2(PAR_BEATS) : 1;

    typedef enum logic {S_MSG = 1'b0, S_PAR = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PB_W-1:0]    pcnt_q, pcnt_d;
    logic [PAR_W-1:0]   rem_q, rem_d;
    logic [7:0]         od_q, od_d;
    logic               ov_q, ov_d;
    logic               op_q, op_d;
    logic               ol_q, ol_d;
    logic               rdy_en_q;
    logic               slot_free;
    logic               abort_w;

`ifdef BCH_ENC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Eight MSB-first LFSR division steps for one input byte.
    function automatic logic [PAR_W-1:0] step8(input logic [PAR_W-1:0] r_in,
                                               input logic [7:0]       d);
        logic [PAR_W-1:0] r;
        logic             fb;
        r = r_in;
        for (int i = 0; i < 8; i++) begin
            fb = r[PAR_W-1] ^ d[7-i];
            r  = {r[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
        return r;
    endfunction

    assign slot_free = !ov_q || out_ready;
    // rdy_en_q keeps in_ready low through reset and until the first edge after release.
    assign in_ready  = rdy_en_q && (state_q == S_MSG) && slot_free;

    assign out_data  = od_q;
    assign out_valid = ov_q;
    assign out_par   = op_q;
    assign out_last  = ol_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        rem_d   = rem_q;
        od_d    = od_q;
        ov_d    = ov_q;
        op_d    = op_q;
        ol_d    = ol_q;
        if (abort_w) begin
            state_d = S_MSG;
            cnt_d   = '0;
            pcnt_d  = '0;
            rem_d   = '0;
            od_d    = '0;
            ov_d    = 1'b0;
            op_d    = 1'b0;
            ol_d    = 1'b0;
        end else if (state_q == S_MSG) begin
            if (in_valid && in_ready) begin
                od_d  = in_data;
                ov_d  = 1'b1;
                op_d  = 1'b0;
                ol_d  = 1'b0;
                rem_d = step8(rem_q, in_data);
                if (cnt_q == CNT_W'(MSG_BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PAR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (out_ready) begin
                ov_d = 1'b0;
            end
        end else if (slot_free) begin
            od_d = rem_q[PAR_W-1 -: 8];
            ov_d = 1'b1;
            op_d = 1'b1;
            if (pcnt_q == PB_W'(PAR_BEATS - 1)) begin
                ol_d    = 1'b1;
                rem_d   = '0;
                pcnt_d  = '0;
                state_d = S_MSG;
            end else begin
                ol_d   = 1'b0;
                rem_d  = rem_q << 8;
                pcnt_d = pcnt_q + PB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_MSG;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            rem_q    <= '0;
            od_q     <= '0;
            ov_q     <= 1'b0;
            op_q     <= 1'b0;
            ol_q     <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            rem_q    <= rem_d;
            od_q     <= od_d;
            ov_q     <= ov_d;
            op_q     <= op_d;
            ol_q     <= ol_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bch_encoder_p8.sv
// Directed table-driven bench for bch_encoder_p8 at default parameters,
// with hand sequences for backpressure, back-to-back codewords and reset/abort.
module tb_bch_encoder_p8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_par;
    logic       out_last;
`ifdef BCH_ENC_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef logic [9:0] beat_t;   // {data, par, last}
    typedef struct {
        logic [31:0] msg;         // first beat in [31:24]
        logic [15:0] par;         // first parity beat in [15:8]
        string       name;
    } vec_t;

    vec_t       tbl[5];
    logic [7:0] stim_q[$];
    beat_t      exp_q[$];
    beat_t      got_q[$];

    always #5 clk = ~clk;

    bch_encoder_p8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BCH_ENC_ABORT_EN
        .abort     (abort),
`endif
        .out_par   (out_par),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cw(input logic [31:0] msg, input logic [15:0] par);
        for (int b = 0; b < 4; b++) begin
            stim_q.push_back(msg[31-8*b -: 8]);
            exp_q.push_back({msg[31-8*b -: 8], 1'b0, 1'b0});
        end
        exp_q.push_back({par[15:8], 1'b1, 1'b0});
        exp_q.push_back({par[7:0], 1'b1, 1'b1});
    endtask

    // mode 0: out_ready=1 always; mode 1: out_ready toggles every cycle.
    task automatic run_stream(input int mode, input string name);
        int    idx;
        int    cyc;
        logic  stall;
        logic  extra;
        beat_t held;
        idx   = 0;
        cyc   = 0;
        stall = 1'b0;
        held  = '0;
        got_q.delete();
        while (got_q.size() < exp_q.size() && cyc < 2000) begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (idx < stim_q.size()) begin
                in_valid = 1'b1;
                in_data  = stim_q[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall)
                check({name, " hold"}, {21'd0, out_valid, out_data, out_par, out_last}, {21'd0, 1'b1, held});
            stall = out_valid && !out_ready;
            held  = {out_data, out_par, out_last};
            if (out_valid && out_par && !out_last)
                check({name, " in_ready in PAR"}, {31'd0, in_ready}, 32'd0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got_q.push_back({out_data, out_par, out_last});
            cyc++;
        end
        in_valid = 1'b0;
        check({name, " beat count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s beat %0d", name, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
        out_ready = 1'b1;
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid) extra = 1'b1;
        end
        check({name, " no extra beats"}, {31'd0, extra}, 32'd0);
        $display("%s: %0d beats received", name, got_q.size());
    endtask

    task automatic feed_two_beats();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'h55 + 8'(b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // Remainders of m(x)*x^13 mod (x^13+x^4+x^3+x+1), split into two bytes.
        tbl[0] = '{32'h0000_0000, 16'h0000, "zeros"};
        tbl[1] = '{32'h0000_0001, 16'h00D8, "m01"};   // rem 0x001B
        tbl[2] = '{32'h0000_0002, 16'h01B0, "m02"};   // rem 0x0036
        tbl[3] = '{32'h0000_0003, 16'h0168, "m03"};   // rem 0x002D
        tbl[4] = '{32'h0000_0010, 16'h0D80, "m10"};   // rem 0x01B0

        repeat (3) @(negedge clk);
        #1;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready",  {31'd0, in_ready},  32'd0);
        check("rst out_data",  {24'd0, out_data},  32'd0);
        check("rst out_par",   {31'd0, out_par},   32'd0);
        check("rst out_last",  {31'd0, out_last},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready after release", {31'd0, in_ready}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            stim_q.delete();
            exp_q.delete();
            push_cw(tbl[v].msg, tbl[v].par);
            run_stream(0, tbl[v].name);
        end

        stim_q.delete();
        exp_q.delete();
        push_cw(tbl[1].msg, tbl[1].par);
        run_stream(1, "m01 backpressure");

        stim_q.delete();
        exp_q.delete();
        push_cw(tbl[1].msg, tbl[1].par);
        push_cw(tbl[2].msg, tbl[2].par);
        run_stream(0, "back-to-back");

        stim_q.delete();
        exp_q.delete();
        push_cw(tbl[2].msg, tbl[2].par);
        push_cw(tbl[4].msg, tbl[4].par);
        run_stream(1, "back-to-back backpressure");

        feed_two_beats();
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim_q.delete();
        exp_q.delete();
        push_cw(tbl[1].msg, tbl[1].par);
        run_stream(0, "after reset");

`ifdef BCH_ENC_ABORT_EN
        feed_two_beats();
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        stim_q.delete();
        exp_q.delete();
        push_cw(tbl[1].msg, tbl[1].par);
        run_stream(0, "after abort");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
